// File: rtl/uart_loopback_top.sv
// UART 8-N-1 transmitter and receiver joined by one internal serial line.
// A one-cycle trigger sends a byte; the receiver reports it with a one-cycle strobe.
module uart_loopback_top #(
    parameter int unsigned BAUD_CNT = 50
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       tx_trig,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       po_flag
);

    localparam int unsigned CntW = $clog2(BAUD_CNT);
    localparam logic [CntW-1:0] CntMax = CntW'(BAUD_CNT - 1);
    localparam logic [CntW-1:0] CntMid = CntW'(BAUD_CNT / 2 - 1);

    typedef enum logic {TxIdle, TxBusy} tx_state_e;
    typedef enum logic {RxIdle, RxRecv} rx_state_e;

    tx_state_e       r_tx_state, w_tx_state_nxt;
    logic [CntW-1:0] r_tx_cnt;
    logic [3:0]      r_tx_bit;
    logic [7:0]      r_tx_shift;
    logic            r_tx_line;
    logic            w_tx_start, w_tx_bit_end, w_tx_done;

    rx_state_e       r_rx_state, w_rx_state_nxt;
    logic [CntW-1:0] r_rx_cnt;
    logic [3:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic [7:0]      r_rx_data;
    logic            r_po_flag;
    logic            r_sync1, r_sync2, r_sync3;
    logic            w_fall, w_rx_sample, w_rx_glitch, w_rx_last;

    // ---------------- Transmitter ----------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TxIdle;
        else        r_tx_state <= w_tx_state_nxt;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        unique case (r_tx_state)
            TxIdle:  if (tx_trig)   w_tx_state_nxt = TxBusy;
            TxBusy:  if (w_tx_done) w_tx_state_nxt = TxIdle;
            default: w_tx_state_nxt = TxIdle;
        endcase
    end

    always_comb begin
        w_tx_start   = (r_tx_state == TxIdle) && tx_trig;
        w_tx_bit_end = (r_tx_state == TxBusy) && (r_tx_cnt == CntMax);
        w_tx_done    = w_tx_bit_end && (r_tx_bit == 4'd9);
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
        end else if (w_tx_start) begin
            r_tx_shift <= tx_data;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_line  <= 1'b0;
        end else if (r_tx_state == TxBusy) begin
            if (w_tx_bit_end) begin
                r_tx_cnt <= '0;
                r_tx_bit <= w_tx_done ? 4'd0 : r_tx_bit + 4'd1;
                // Bits 0..7 ended: put the next data bit out; otherwise stop/idle level.
                if (r_tx_bit < 4'd8) begin
                    r_tx_line  <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                end else begin
                    r_tx_line <= 1'b1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- Receiver ----------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= r_tx_line;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_fall = r_sync3 & ~r_sync2;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RxIdle;
        else        r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        unique case (r_rx_state)
            RxIdle:  if (w_fall)                   w_rx_state_nxt = RxRecv;
            RxRecv:  if (w_rx_glitch || w_rx_last) w_rx_state_nxt = RxIdle;
            default: w_rx_state_nxt = RxIdle;
        endcase
    end

    always_comb begin
        w_rx_sample = (r_rx_state == RxRecv) && (r_rx_cnt == CntMid);
        w_rx_glitch = w_rx_sample && (r_rx_bit == 4'd0) && r_sync2;
        w_rx_last   = w_rx_sample && (r_rx_bit == 4'd9);
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_po_flag  <= 1'b0;
        end else begin
            r_po_flag <= w_rx_last && r_sync2;
            if (w_rx_last && r_sync2) r_rx_data <= r_rx_shift;
            if (r_rx_state == RxIdle) begin
                if (w_fall) begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                end
            end else begin
                r_rx_cnt <= (r_rx_cnt == CntMax) ? '0 : r_rx_cnt + 1'b1;
                if (w_rx_sample) begin
                    r_rx_bit <= r_rx_bit + 4'd1;
                    if (r_rx_bit >= 4'd1 && r_rx_bit <= 4'd8)
                        r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                end
            end
        end
    end

    assign rx_data = r_rx_data;
    assign po_flag = r_po_flag;

endmodule

// File: tb/tb_uart_loopback_top.sv
// Directed bench for uart_loopback_top: reset, single bytes, sequences, busy trigger,
// back-to-back frames and mid-frame reset, timed against the trigger edge.
module tb_uart_loopback_top;

    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_trig = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       po_flag;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         pulse_cyc[$];
    logic [7:0] pulse_dat[$];

    uart_loopback_top #(.BAUD_CNT(50)) dut (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .tx_trig (tx_trig),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .po_flag (po_flag)
    );

    always #10 sclk = ~sclk;

    // cyc equals N after rising edge N
    always @(posedge sclk) cyc <= cyc + 1;

    always @(negedge sclk) begin
        if (po_flag) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(rx_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge sclk);
    endtask

    task automatic clear_pulses();
        pulse_cyc.delete();
        pulse_dat.delete();
    endtask

    // Drives a one-cycle trigger; t returns the rising edge that samples it.
    task automatic send(input logic [7:0] d, output int t);
        tx_data = d;
        tx_trig = 1'b1;
        t = cyc + 1;
        @(negedge sclk);
        tx_trig = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input int t);
        wait_to(t + 520);
        check_eq({tag, "_npulse"}, pulse_cyc.size(), 1);
        if (pulse_cyc.size() > 0) begin
            check_eq({tag, "_time"}, pulse_cyc[0], t + 478);
            check_eq({tag, "_pdata"}, pulse_dat[0], d);
        end
        check_eq({tag, "_rxdata"}, rx_data, d);
    endtask

    initial begin
        int         t, t2;
        logic [9:0] bits;
        logic [7:0] seq  [4] = '{8'h37, 8'hFA, 8'h00, 8'hFF};
        logic [7:0] prev [4] = '{8'h4E, 8'h37, 8'hFA, 8'h00};

        // Reset
        repeat (10) @(negedge sclk);
        check_eq("rst_rxdata", rx_data, 8'h00);
        check_eq("rst_flag", po_flag, 1'b0);
        check_eq("rst_line", dut.r_tx_line, 1'b1);
        rst_n = 1'b1;
        clear_pulses();
        repeat (1000) @(negedge sclk);
        check_eq("rst_nopulse", pulse_cyc.size(), 0);
        check_eq("rst_line_idle", dut.r_tx_line, 1'b1);

        // Single byte 4E with line bit sequence 0,0,1,1,1,0,0,1,0,1
        clear_pulses();
        send(8'h4E, t);
        for (int k = 0; k < 10; k++) begin
            wait_to(t + 25 + 50 * k);
            bits[k] = dut.r_tx_line;
        end
        check_eq("b4e_bits", bits, 10'b1010011100);
        expect_frame("b4e", 8'h4E, t);

        // Sequence with 1000-cycle gaps; rx_data holds the previous byte until the pulse
        for (int i = 0; i < 4; i++) begin
            clear_pulses();
            send(seq[i], t);
            wait_to(t + 477);
            check_eq($sformatf("seq%0d_hold", i), rx_data, prev[i]);
            expect_frame($sformatf("seq%0d", i), seq[i], t);
            wait_to(t + 1000);
        end

        // Trigger while busy is ignored
        clear_pulses();
        send(8'hA5, t);
        wait_to(t + 99);
        tx_data = 8'h5A;
        tx_trig = 1'b1;
        @(negedge sclk);
        tx_trig = 1'b0;
        wait_to(t + 500);
        check_eq("busy_tx_idle", dut.r_tx_state, 0);
        check_eq("busy_line", dut.r_tx_line, 1'b1);
        expect_frame("busy", 8'hA5, t);
        wait_to(t + 1100);
        check_eq("busy_npulse_late", pulse_cyc.size(), 1);

        // Back-to-back: second trigger sampled at T+501
        clear_pulses();
        send(8'h55, t);
        wait_to(t + 500);
        send(8'hAA, t2);
        wait_to(t2 + 520);
        check_eq("b2b_npulse", pulse_cyc.size(), 2);
        if (pulse_cyc.size() == 2) begin
            check_eq("b2b_time0", pulse_cyc[0], t + 478);
            check_eq("b2b_time1", pulse_cyc[1], t + 979);
            check_eq("b2b_data0", pulse_dat[0], 8'h55);
            check_eq("b2b_data1", pulse_dat[1], 8'hAA);
        end

        // Mid-frame reset aborts the frame
        clear_pulses();
        send(8'hC3, t);
        wait_to(t + 199);
        rst_n = 1'b0;
        repeat (5) @(negedge sclk);
        check_eq("mrst_rxdata", rx_data, 8'h00);
        check_eq("mrst_line", dut.r_tx_line, 1'b1);
        check_eq("mrst_flag", po_flag, 1'b0);
        rst_n = 1'b1;
        repeat (1000) @(negedge sclk);
        check_eq("mrst_nopulse", pulse_cyc.size(), 0);
        check_eq("mrst_rxdata_after", rx_data, 8'h00);
        clear_pulses();
        send(8'h3C, t);
        expect_frame("post_rst", 8'h3C, t);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
